// File: rtl/lv_int_pkg.sv
// Shared types and constants for the LV interrupt controller.
package lv_int_pkg;

    localparam int unsigned ST1_W = 7;
    localparam int unsigned ST2_W = 8;
    localparam int unsigned SRC_W = ST1_W + ST2_W;

    // Bit positions inside the concatenated {status2, status1} source vector
    localparam int unsigned SRC_SPI_ERR      = 0;
    localparam int unsigned SRC_CRC_ERR      = 1;
    localparam int unsigned SRC_COM_ERR      = 2;
    localparam int unsigned SRC_WDG_ERR      = 3;
    localparam int unsigned SRC_PWM_DTERR    = 4;
    localparam int unsigned SRC_PWM_MMERR    = 5;
    localparam int unsigned SRC_BIST_FAIL    = 6;
    localparam int unsigned SRC_LV_VSUP_UV   = 7;
    localparam int unsigned SRC_LV_VSUP_OV   = 8;
    localparam int unsigned SRC_HV_VCC_UV    = 9;
    localparam int unsigned SRC_HV_VCC_OV    = 10;
    localparam int unsigned SRC_HV_OT        = 11;
    localparam int unsigned SRC_HV_OC        = 12;
    localparam int unsigned SRC_HV_DESAT_FLT = 13;
    localparam int unsigned SRC_HV_SCP       = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } int_state_e;

    // Larger of two unsigned values, usable in constant expressions
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lv_int_edge_det.sv
// Per-bit rising-edge detector with sticky capture, cleared by acknowledge.
module lv_int_edge_det #(
    parameter int unsigned W = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_flags,
    input  logic         i_clr,
    output logic [W-1:0] o_src,
    output logic         o_rise_any_c
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;
    logic [W-1:0] src_q;
    logic [W-1:0] src_d;
    logic [W-1:0] rise_c;

    // Edge detect; a new edge coincident with acknowledge survives the clear
    always_comb begin
        rise_c = i_flags & ~prev_q;
        prev_d = i_flags;
        src_d  = i_clr ? rise_c : (src_q | rise_c);
    end

    // Previous-level and sticky-source registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= '0;
            src_q  <= '0;
        end else begin
            prev_q <= prev_d;
            src_q  <= src_d;
        end
    end

    assign o_src        = src_q;
    assign o_rise_any_c = |rise_c;

endmodule

// File: rtl/lv_int_ctrl.sv
// Interrupt pin controller: captures new faults and drives a min-width INTB pulse.
module lv_int_ctrl
    import lv_int_pkg::*;
#(
    parameter int unsigned INTB_MIN_LOW_CYC = 16,
    parameter int unsigned INTB_GAP_CYC     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ST1_W-1:0]  i_status1_flt,
    input  logic [ST2_W-1:0]  i_status2_flt,
    input  logic              i_int_en,
    input  logic              i_int_clr,
    output logic              o_intb_n,
    output logic              o_int_pending,
    output logic [SRC_W-1:0]  o_int_src,
    output logic              o_fault_req
);

    localparam int unsigned CNT_W = $clog2(max_u(INTB_MIN_LOW_CYC, INTB_GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(INTB_MIN_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(INTB_GAP_CYC - 1);

    logic [SRC_W-1:0] flags_c;
    logic [SRC_W-1:0] src_w;
    logic             rise_any_c;

    logic             pending_q;
    logic             pending_d;
    logic             fault_req_q;
    logic             fault_req_d;
    int_state_e       state_q;
    int_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;

    assign flags_c = {i_status2_flt, i_status1_flt};

    lv_int_edge_det #(
        .W (SRC_W)
    ) u_edge_det (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flags      (flags_c),
        .i_clr        (i_int_clr),
        .o_src        (src_w),
        .o_rise_any_c (rise_any_c)
    );

    // Pending flag and fault request next-state
    always_comb begin
        pending_d   = rise_any_c | (pending_q & ~i_int_clr);
        fault_req_d = |flags_c[SRC_HV_SCP:SRC_HV_OT];
    end

    // Pin FSM next-state; counter saturates rather than wrapping
    always_comb begin
        state_d   = state_q;
        cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d     = cnt_q;
        if (!i_int_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (pending_q) begin
                        state_d = ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if ((cnt_q >= LOW_LAST) && !pending_q) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                ST_GAP: begin
                    if (cnt_q >= GAP_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, pending and fault request registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            fault_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            fault_req_q <= fault_req_d;
        end
    end

    assign o_intb_n      = (state_q != ST_ASSERT);
    assign o_int_pending = pending_q;
    assign o_int_src     = src_w;
    assign o_fault_req   = fault_req_q;

endmodule

// File: tb/tb_lv_int_ctrl.sv
// Self-checking bench for lv_int_ctrl: reference model feeding a scoreboard plus directed checks.
module tb_lv_int_ctrl;

    localparam int unsigned MIN_LOW = 16;
    localparam int unsigned GAP     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  s1;
    logic [7:0]  s2;
    logic        en;
    logic        clr;
    logic        intb_n;
    logic        pend;
    logic [14:0] src;
    logic        fault;

    always #5 clk = ~clk;

    lv_int_ctrl #(
        .INTB_MIN_LOW_CYC (MIN_LOW),
        .INTB_GAP_CYC     (GAP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_status1_flt (s1),
        .i_status2_flt (s2),
        .i_int_en      (en),
        .i_int_clr     (clr),
        .o_intb_n      (intb_n),
        .o_int_pending (pend),
        .o_int_src     (src),
        .o_fault_req   (fault)
    );

    typedef struct packed {
        logic        intb_n;
        logic        pend;
        logic [14:0] src;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [14:0] m_prev;
    logic [14:0] m_src;
    logic        m_pend;
    logic        m_fault;
    int          m_state;   // 0 idle, 1 low, 2 gap
    int          m_cnt;

    // Observed pin run lengths
    int cur_low   = 0;
    int cur_high  = 0;
    int last_low  = 0;
    int last_high = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [14:0] cur;
        logic [14:0] rise;
        exp_t        e;
        cur = {s2, s1};
        if (rst) begin
            m_prev = '0; m_src = '0; m_pend = 1'b0; m_fault = 1'b0;
            m_state = 0; m_cnt = 0;
        end else begin
            rise = cur & ~m_prev;
            if (!en) begin
                m_state = 0;
                m_cnt   = 0;
            end else begin
                case (m_state)
                    0: if (m_pend) begin m_state = 1; m_cnt = 0; end
                    1: if (m_cnt >= int'(MIN_LOW) - 1 && !m_pend) begin
                           m_state = 2; m_cnt = 0;
                       end else m_cnt++;
                    default: if (m_cnt >= int'(GAP) - 1) begin
                           m_state = 0; m_cnt = 0;
                       end else m_cnt++;
                endcase
            end
            m_pend  = (rise != 0) | (m_pend & ~clr);
            m_src   = clr ? rise : (m_src | rise);
            m_prev  = cur;
            m_fault = |s2[7:4];
        end
        e.intb_n = (m_state != 1);
        e.pend   = m_pend;
        e.src    = m_src;
        e.fault  = m_fault;
        sb_q.push_back(e);
    endtask

    // One clock: predict, wait for the edge, compare against the scoreboard
    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_intb_n", 32'(intb_n), 32'(e.intb_n));
        chk("sb_pend",   32'(pend),   32'(e.pend));
        chk("sb_src",    32'(src),    32'(e.src));
        chk("sb_fault",  32'(fault),  32'(e.fault));
        if (intb_n === 1'b0) begin
            if (cur_high > 0) last_high = cur_high;
            cur_high = 0;
            cur_low++;
        end else begin
            if (cur_low > 0) last_low = cur_low;
            cur_low = 0;
            cur_high++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int any_low;

    initial begin
        rst = 1'b1; s1 = '0; s2 = '0; en = 1'b1; clr = 1'b0;
        @(negedge clk);
        run(2);
        chk("rst_intb_n", 32'(intb_n), 32'd1);
        chk("rst_pend",   32'(pend),   32'd0);
        chk("rst_src",    32'(src),    32'd0);
        chk("rst_fault",  32'(fault),  32'd0);

        // Flag already high at reset release
        s2 = 8'h80;
        cyc();
        rst = 1'b0;
        cyc();
        chk("r029_src",   32'(src),    32'h4000);
        chk("r029_fault", 32'(fault),  32'd1);
        chk("r029_intb1", 32'(intb_n), 32'd1);
        cyc();
        chk("r029_intb2", 32'(intb_n), 32'd0);
        clr = 1'b1; cyc(); clr = 1'b0;
        run(30);
        s2 = 8'h00;
        run(5);

        // Single edge, acknowledge early: exactly the minimum low width
        s1 = 7'h01;
        cyc();
        chk("r030_pend", 32'(pend), 32'd1);
        cyc();
        chk("r030_fall", 32'(intb_n), 32'd0);
        run(2);
        clr = 1'b1; cyc(); clr = 1'b0;
        run(20);
        chk("r030_low", 32'(last_low), 32'd16);
        chk("r030_high", 32'(intb_n), 32'd1);
        s1 = 7'h00;
        run(3);

        // Acknowledge coinciding with a new edge during the gap
        s1 = 7'h01;
        run(2);
        run(2);
        clr = 1'b1; cyc(); clr = 1'b0;
        run(13);
        cyc();
        chk("r031_gap0", 32'(intb_n), 32'd1);
        clr = 1'b1; s2 = 8'h04; cyc(); clr = 1'b0;
        chk("r031_pend", 32'(pend), 32'd1);
        chk("r031_src",  32'(src),  32'h0200);
        run(3);
        cyc();
        chk("r031_refall", 32'(intb_n), 32'd0);
        chk("r031_gaplen", 32'(last_high >= 4), 32'd1);
        cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        run(20);
        chk("r031_low2", 32'(last_low), 32'd16);

        // Disabled pin still captures; enabling asserts on the next cycle
        en = 1'b0;
        s1 = 7'h21;
        run(4);
        chk("r032_intb", 32'(intb_n), 32'd1);
        chk("r032_pend", 32'(pend),   32'd1);
        chk("r032_src",  32'(src),    32'h0020);
        en = 1'b1;
        cyc();
        chk("r032_fall", 32'(intb_n), 32'd0);
        clr = 1'b1; cyc(); clr = 1'b0;
        run(25);

        // Held level stays quiet; drop and re-raise asserts again
        any_low = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (intb_n !== 1'b1) any_low = 1;
        end
        chk("r033_quiet", 32'(any_low), 32'd0);
        s1 = 7'h01;
        run(2);
        s1 = 7'h21;
        run(2);
        chk("r033_refall", 32'(intb_n), 32'd0);

        // Reset in the middle of the low pulse
        run(4);
        rst = 1'b1; s2 = 8'h30;
        cyc();
        chk("r034_intb",  32'(intb_n), 32'd1);
        chk("r034_pend",  32'(pend),   32'd0);
        chk("r034_src",   32'(src),    32'd0);
        chk("r034_fault", 32'(fault),  32'd0);
        rst = 1'b0;
        run(3);
        chk("r034_fault_lvl", 32'(fault), 32'd1);

        // Enable dropped mid-pulse releases the pin immediately
        en = 1'b0;
        cyc();
        chk("r021_en_off", 32'(intb_n), 32'd1);
        en = 1'b1;
        s2 = 8'h00;

        // Randomised traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) s1 = 7'($urandom);
            if ($urandom_range(0, 7) == 0) s2 = 8'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; clr = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
